// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if
//   Bundles the host-side request/response signals and the SPI pins of the
//   SPI initiator.
//   master modport : the controller (drives busy/done/rd_*, SS_n, MOSI)
//   slave modport  : the host plus the SPI slave (drives start/cmd/wdata, MISO)
//   start    host request pulse
//   cmd      2-bit frame command
//   wdata    8-bit payload
//   busy     frame in progress
//   done     one-cycle end-of-frame pulse
//   rd_data  last byte received on MISO
//   rd_valid one-cycle pulse with done for read-data frames
//   SS_n     slave select, active low
//   MOSI     serial out, MSB first
//   MISO     serial in, MSB first
interface spi_master_ctrl_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, wdata, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI
    );

    modport slave (
        output start, cmd, wdata, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   SPI initiator: turns a {cmd, wdata} request into one serial frame on
//   SS_n/MOSI and, for read-data frames (cmd=11), shifts 8 bits back in on
//   MISO after RD_LAT wait cycles.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_master_ctrl_if.master (request, status, SPI pins)
//   RD_LAT : wait cycles between last MOSI bit and first MISO sample (1..15)
//   GAP    : SS_n high cycles between frames (1..7)
module spi_master_ctrl #(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_ctrl_if.master   bus
);

    localparam int MAXV  = (RD_LAT > 10) ? ((RD_LAT > GAP) ? RD_LAT : GAP)
                                         : ((GAP > 10) ? GAP : 10);
    localparam int CNT_W = $clog2(MAXV + 1);
    // busy stays high on STOP entry only when the gap is longer than one cycle
    localparam logic STOP_BUSY = (GAP > 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SHIFT, S_WAIT, S_READ, S_STOP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [9:0]         r_shift;
    logic               r_rd_cmd;
    logic [7:0]         r_rd_shift;
    logic               r_ss_n;
    logic               r_mosi;
    logic               r_busy;
    logic               r_done;
    logic               r_rd_valid;
    logic [7:0]         r_rd_data;

    logic               w_stop_last;
    logic               w_accept;
    logic [7:0]         w_rd_next;

    // busy drops for the last STOP cycle so a start held there launches the
    // next frame immediately, giving exactly GAP high cycles on SS_n.
    assign w_stop_last = (r_state == S_STOP) && (r_cnt == CNT_W'(GAP - 1));
    assign w_accept    = bus.start && ((r_state == S_IDLE) || w_stop_last);
    assign w_rd_next   = {r_rd_shift[6:0], bus.MISO};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_rd_cmd   <= 1'b0;
            r_rd_shift <= '0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_accept) begin
                r_shift  <= {bus.cmd, bus.wdata};
                r_rd_cmd <= (bus.cmd == 2'b11);
                r_busy   <= 1'b1;
                r_ss_n   <= 1'b0;
                r_mosi   <= bus.cmd[1];
                r_cnt    <= '0;
                r_state  <= S_START;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_ss_n <= 1'b1;
                        r_mosi <= 1'b0;
                    end
                    S_START: begin
                        r_mosi  <= r_shift[9];
                        r_shift <= {r_shift[8:0], 1'b0};
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (r_cnt == CNT_W'(9)) begin
                            r_mosi <= 1'b0;
                            r_cnt  <= '0;
                            if (r_rd_cmd) begin
                                r_state <= S_WAIT;
                            end else begin
                                r_ss_n  <= 1'b1;
                                r_done  <= 1'b1;
                                r_busy  <= STOP_BUSY;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_mosi  <= r_shift[9];
                            r_shift <= {r_shift[8:0], 1'b0};
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (r_cnt == CNT_W'(RD_LAT - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_READ: begin
                        r_rd_shift <= w_rd_next;
                        if (r_cnt == CNT_W'(7)) begin
                            r_ss_n     <= 1'b1;
                            r_done     <= 1'b1;
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= w_rd_next;
                            r_busy     <= STOP_BUSY;
                            r_cnt      <= '0;
                            r_state    <= S_STOP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (w_stop_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            if (r_cnt == CNT_W'(GAP - 2)) r_busy <= 1'b0;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_ss_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.SS_n     = r_ss_n;
    assign bus.MOSI     = r_mosi;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;

endmodule
